// File: rtl/pipe_sequencer.sv
// Stall/flush sequencer for the decode/execute/writeback pipeline: buffer and PC
// write enables, bubble insertion, multiplier occupancy, branch watchdog, stall count.
module pipe_sequencer #(
  parameter int MULT_LAT = 4,
  parameter int WAIT_MAX = 7
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dec_valid,
  input  logic        dec_has_stall,
  input  logic        dec_is_mult,
  input  logic        dec_uses_hilo,
  input  logic        wb_resolved,
  input  logic        wb_taken,
  output logic        pc_wr,
  output logic        pc_redirect,
  output logic        dec_exe_wr,
  output logic        bubble,
  output logic        exe_wb_wr,
  output logic        mult_start,
  output logic        mult_busy,
  output logic        wd_err,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT);
  localparam logic [3:0] WD_LAST   = 4'(WAIT_MAX - 1);

  logic [1:0]  cur_state;
  logic [1:0]  nxt_state;
  logic [3:0]  mult_cnt;
  logic [3:0]  wd_cnt;
  logic        err_sticky;
  logic [15:0] stall_reg;

  logic        hazard;
  logic        enter_wait;
  logic        timeout;
  logic        pc_wr_c;
  logic        redirect_c;
  logic        bubble_c;
  logic        mult_start_c;

  assign hazard = dec_valid & (dec_is_mult | dec_uses_hilo) & (mult_cnt != 4'd0);

  // Next-state and per-cycle control decode (Mealy on current inputs)
  always_comb begin
    nxt_state    = cur_state;
    enter_wait   = 1'b0;
    timeout      = 1'b0;
    pc_wr_c      = 1'b0;
    redirect_c   = 1'b0;
    bubble_c     = 1'b0;
    mult_start_c = 1'b0;
    case (cur_state)
      S_RUN: begin
        if (!dec_valid) begin
          pc_wr_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (hazard) begin
          bubble_c = 1'b1;
        end else if (dec_has_stall) begin
          // Control instruction wins over a simultaneous multiply flag.
          nxt_state  = S_WAIT;
          enter_wait = 1'b1;
        end else begin
          pc_wr_c      = 1'b1;
          mult_start_c = dec_is_mult;
        end
      end
      S_WAIT: begin
        bubble_c = 1'b1;
        if (wb_resolved) begin
          pc_wr_c    = 1'b1;
          redirect_c = wb_taken;
          nxt_state  = S_FLUSH;
        end else if (wd_cnt >= WD_LAST) begin
          // Give up on the resolution and fall through to PC+1.
          timeout   = 1'b1;
          pc_wr_c   = 1'b1;
          nxt_state = S_FLUSH;
        end else begin
          nxt_state = S_WAIT;
        end
      end
      S_FLUSH: begin
        bubble_c  = 1'b1;
        nxt_state = S_RUN;
      end
      default: begin
        bubble_c  = 1'b1;
        nxt_state = S_RUN;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur_state <= S_RUN;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Multiplier occupancy countdown, runs in every state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mult_cnt <= 4'd0;
    end else if (mult_start_c) begin
      mult_cnt <= MULT_LOAD;
    end else if (mult_cnt != 4'd0) begin
      mult_cnt <= mult_cnt - 4'd1;
    end
  end

  // Watchdog counter and sticky error
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_cnt     <= 4'd0;
      err_sticky <= 1'b0;
    end else begin
      if (enter_wait) begin
        wd_cnt <= 4'd0;
      end else if (cur_state == S_WAIT) begin
        wd_cnt <= wd_cnt + 4'd1;
      end
      if (timeout) begin
        err_sticky <= 1'b1;
      end
    end
  end

  // Saturating bubble counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_reg <= 16'd0;
    end else if (bubble_c && (stall_reg != 16'hFFFF)) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  // Reset forces every output low immediately, independent of the clock.
  assign pc_wr       = pc_wr_c & ~RST;
  assign pc_redirect = redirect_c & ~RST;
  assign dec_exe_wr  = ~RST;
  assign exe_wb_wr   = ~RST;
  assign bubble      = bubble_c & ~RST;
  assign mult_start  = mult_start_c & ~RST;
  assign mult_busy   = (mult_cnt != 4'd0) & ~RST;
  assign wd_err      = (err_sticky | timeout) & ~RST;
  assign state       = RST ? S_RUN : cur_state;
  assign stall_cnt   = RST ? 16'd0 : stall_reg;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer: timestamp-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_pipe_sequencer;
  localparam int MULT_LAT = 4;
  localparam int WAIT_MAX = 7;

  logic clk, rst;
  logic dec_valid, dec_has_stall, dec_is_mult, dec_uses_hilo, wb_resolved, wb_taken;
  logic pc_wr, pc_redirect, dec_exe_wr, bubble, exe_wb_wr, mult_start, mult_busy, wd_err;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  pipe_sequencer #(.MULT_LAT(MULT_LAT), .WAIT_MAX(WAIT_MAX)) dut (
    .CLK(clk), .RST(rst),
    .dec_valid(dec_valid), .dec_has_stall(dec_has_stall), .dec_is_mult(dec_is_mult),
    .dec_uses_hilo(dec_uses_hilo), .wb_resolved(wb_resolved), .wb_taken(wb_taken),
    .pc_wr(pc_wr), .pc_redirect(pc_redirect), .dec_exe_wr(dec_exe_wr), .bubble(bubble),
    .exe_wb_wr(exe_wb_wr), .mult_start(mult_start), .mult_busy(mult_busy), .wd_err(wd_err),
    .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: absolute cycle timestamps instead of down-counters.
  int m_cyc, m_mult_last, m_wait_start, m_ph, m_stalls;
  bit m_err;
  logic e_pc_wr, e_redir, e_dx, e_bub, e_ms, e_busy, e_err, m_to, m_res, m_go_wait;
  logic [1:0] e_state;
  logic [15:0] e_stall;

  always_comb begin
    e_pc_wr = 0; e_redir = 0; e_dx = 0; e_bub = 0; e_ms = 0; e_busy = 0; e_err = 0;
    e_state = 2'd0; e_stall = 16'd0; m_to = 0; m_res = 0; m_go_wait = 0;
    if (!rst) begin
      e_busy  = (m_cyc <= m_mult_last);
      e_dx    = 1;
      e_state = 2'(m_ph);
      e_stall = 16'(m_stalls);
      e_err   = m_err;
      if (m_ph == 0) begin
        if (!dec_valid) begin
          e_pc_wr = 1; e_bub = 1;
        end else if ((dec_is_mult || dec_uses_hilo) && e_busy) begin
          e_bub = 1;
        end else if (dec_has_stall) begin
          m_go_wait = 1;
        end else begin
          e_pc_wr = 1; e_ms = dec_is_mult;
        end
      end else if (m_ph == 1) begin
        e_bub = 1;
        if (wb_resolved) begin
          e_pc_wr = 1; e_redir = wb_taken; m_res = 1;
        end else if (m_cyc - m_wait_start + 1 >= WAIT_MAX) begin
          m_to = 1; e_pc_wr = 1; e_err = 1;
        end
      end else begin
        e_bub = 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_cyc <= 0; m_mult_last <= -1; m_wait_start <= 0; m_ph <= 0; m_stalls <= 0; m_err <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (e_bub) m_stalls <= (m_stalls >= 65535) ? 65535 : m_stalls + 1;
      if (e_ms) m_mult_last <= m_cyc + MULT_LAT;
      if (m_to) m_err <= 1;
      if (m_go_wait) begin
        m_ph <= 1; m_wait_start <= m_cyc + 1;
      end else if (m_ph == 1 && (m_res || m_to)) begin
        m_ph <= 2;
      end else if (m_ph == 2) begin
        m_ph <= 0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl{pc_wr,redir,dx,xw,bub,ms,busy,err}",
            {24'd0, pc_wr, pc_redirect, dec_exe_wr, exe_wb_wr, bubble, mult_start, mult_busy, wd_err},
            {24'd0, e_pc_wr, e_redir, e_dx, e_dx, e_bub, e_ms, e_busy, e_err});
      check("state", {30'd0, state}, {30'd0, e_state});
      check("stall_cnt", {16'd0, stall_cnt}, {16'd0, e_stall});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic peek();
    @(negedge clk); #2;
  endtask

  task automatic drive(input logic v, input logic st, input logic mu, input logic hl);
    dec_valid = v; dec_has_stall = st; dec_is_mult = mu; dec_uses_hilo = hl;
  endtask

  task automatic run_branch(input logic taken);
    drive(1, 1, 0, 0); step();
    drive(1, 0, 0, 0); peek(); check("br_c1_state", 32'(state), 32'd1); step();
    step();
    wb_resolved = 1; wb_taken = taken;
    peek(); check("br_c3_pc_wr", 32'(pc_wr), 32'd1); check("br_c3_redirect", 32'(pc_redirect), 32'(taken));
    step();
    wb_resolved = 0; wb_taken = 0;
    peek(); check("br_c4_state", 32'(state), 32'd2); check("br_c4_redirect", 32'(pc_redirect), 32'd0);
    step();
    peek(); check("br_c5_state", 32'(state), 32'd0); step();
  endtask

  initial begin
    clk = 0; rst = 1;
    drive(0, 0, 0, 0); wb_resolved = 0; wb_taken = 0;
    @(posedge clk); #1; rst = 0; chk_en = 1;
    repeat (3) step();

    // Asynchronous reset in the middle of a multiply and a control wait
    drive(1, 0, 1, 0); step();
    drive(1, 1, 0, 0); step();
    drive(1, 0, 0, 0); step();
    #3 rst = 1; #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc_wr", 32'(pc_wr), 32'd0);
    check("rst_exe_wb_wr", 32'(exe_wb_wr), 32'd0);
    check("rst_mult_busy", 32'(mult_busy), 32'd0);
    check("rst_bubble", 32'(bubble), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Back-to-back multiplies straight out of reset
    drive(1, 0, 1, 0); step(); rst = 0;
    peek(); check("mm_c0_state", 32'(state), 32'd0); check("mm_c0_exe_wb_wr", 32'(exe_wb_wr), 32'd1);
    check("mm_c0_mult_start", 32'(mult_start), 32'd1); step();
    peek(); check("mm_c1_bubble", 32'(bubble), 32'd1); check("mm_c1_pc_wr", 32'(pc_wr), 32'd0);
    check("mm_c1_busy", 32'(mult_busy), 32'd1); step();
    repeat (3) step();
    peek(); check("mm_c5_mult_start", 32'(mult_start), 32'd1); check("mm_c5_stall_cnt", 32'(stall_cnt), 32'd4);
    step();
    drive(0, 0, 0, 0); repeat (6) step();

    run_branch(1'b1);
    run_branch(1'b0);

    // Resolution pulse outside CTRL_WAIT is ignored
    drive(1, 0, 0, 0); wb_resolved = 1; wb_taken = 1;
    peek(); check("ign_redirect", 32'(pc_redirect), 32'd0); check("ign_state", 32'(state), 32'd0);
    step(); wb_resolved = 0; wb_taken = 0; step();

    // Control plus multiply: control wins
    drive(1, 1, 1, 0);
    peek(); check("pri_mult_start", 32'(mult_start), 32'd0); step();
    drive(1, 0, 0, 0);
    peek(); check("pri_state", 32'(state), 32'd1); check("pri_busy", 32'(mult_busy), 32'd0); step();
    wb_resolved = 1; step(); wb_resolved = 0; step(); step();

    // Watchdog: never resolved
    drive(1, 1, 0, 0); step();
    drive(1, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      if (k == 6) begin
        peek(); check("wd_c6_err", 32'(wd_err), 32'd0);
      end else if (k == 7) begin
        peek(); check("wd_c7_err", 32'(wd_err), 32'd1); check("wd_c7_pc_wr", 32'(pc_wr), 32'd1);
      end
      step();
    end
    peek(); check("wd_c8_state", 32'(state), 32'd2); step();
    peek(); check("wd_c9_state", 32'(state), 32'd0); check("wd_c9_err", 32'(wd_err), 32'd1); step();

    // Stall counter saturation
    drive(0, 0, 0, 0);
    repeat (70000) step();
    peek(); check("sat_stall_cnt", 32'(stall_cnt), 32'h0000FFFF); check("sat_err", 32'(wd_err), 32'd1);
    step();

    // Only reset clears the sticky error
    rst = 1; step(); rst = 0;
    peek(); check("clr_err", 32'(wd_err), 32'd0); check("clr_stall_cnt", 32'(stall_cnt), 32'd0);
    step();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
